response_checker: RTL and testbench

RESPONSE_CHECKER -- requirements
Module: response_checker

---
 rtl/checker_pkg.sv | 26 ++
 rtl/golden_model.sv | 29 ++
 rtl/response_checker.sv | 104 ++++++++++
 tb/tb_response_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// Shared definitions for the response checker: FSM encoding, obs bit positions
// and the default run length.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateE;

  localparam int DEFAULT_NUM_VECTORS = 16;

  localparam int OBS_F  = 0;
  localparam int OBS_F1 = 1;
  localparam int OBS_F2 = 2;
  localparam int OBS_F3 = 3;
  localparam int OBS_Y1 = 4;
  localparam int OBS_Y2 = 5;
  localparam int OBS_Y3 = 6;

  localparam int VEC_A = 3;
  localparam int VEC_B = 2;
  localparam int VEC_C = 1;
  localparam int VEC_D = 0;

endpackage

// File: rtl/golden_model.sv
// Combinational reference response for the circuits under test, computed
// directly from the applied 4-bit stimulus.
module golden_model
  import checker_pkg::*;
(
  input  logic [3:0] vec,
  output logic [6:0] exp
);

  logic a, b, c, d;

  always_comb begin
    a = vec[VEC_A];
    b = vec[VEC_B];
    c = vec[VEC_C];
    d = vec[VEC_D];

    exp         = '0;
    exp[OBS_F]  = b | c | ~d;
    exp[OBS_F2] = ~b | ~a | c;
    exp[OBS_F3] = (b ^ d) & ~(a ^ c);
    // F1 is defined in terms of F2 and F3, so it is evaluated after them
    exp[OBS_F1] = ~(exp[OBS_F2] | exp[OBS_F3]);
    exp[OBS_Y1] = a | b;
    exp[OBS_Y2] = a & b;
    exp[OBS_Y3] = a & b;
  end

endmodule

// File: rtl/response_checker.sv
// Compares observed responses against the golden model over a run of
// NUM_VECTORS valid vectors, counting checks and mismatches.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | checking one vector per vec_valid cycle
// DONE  | run complete, results held until next start
module response_checker
  import checker_pkg::*;
#(
  parameter int NUM_VECTORS = DEFAULT_NUM_VECTORS,
  parameter int ERR_W       = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [3:0]       vec,
  input  logic [6:0]       obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] check_count,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid
);

  stateE          state, nextState;
  logic [6:0]     expResp;
  logic           mismatch;
  logic           clearRun;
  logic           doCheck;
  logic [ERR_W:0] countNext;
  logic           lastVec;

  golden_model uGolden (
    .vec (vec),
    .exp (expResp)
  );

  // An X/Z in obs makes the equality unknown, which falls to the mismatch branch
  always_comb begin
    mismatch = 1'b1;
    if (obs == expResp) mismatch = 1'b0;
  end

  assign countNext = {1'b0, check_count} + 1'b1;
  assign lastVec   = (countNext == (ERR_W+1)'(NUM_VECTORS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    clearRun  = 1'b0;
    doCheck   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nextState = RUN;
          clearRun  = 1'b1;
        end
      end
      RUN: begin
        if (vec_valid) begin
          doCheck = 1'b1;
          if (lastVec) nextState = DONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      check_count      <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (clearRun) begin
      check_count      <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (doCheck) begin
      if (check_count != '1) check_count <= check_count + 1'b1;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!first_fail_valid) begin
          first_fail_vec   <= vec;
          first_fail_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_count == '0);

endmodule

// File: tb/tb_response_checker.sv
// Randomized scoreboard bench for response_checker: run results are predicted
// from a behavioural model and checked by a monitor when done rises.
module tb_response_checker;

  typedef struct {
    int         checks;
    int         errs;
    logic       ffValid;
    logic [3:0] ffVec;
  } resT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, start, vecValid;
  logic [3:0] vec;
  logic [6:0] obs;
  logic       busy, done, pass, ffValid;
  logic [4:0] checkCount, errCount;
  logic [3:0] ffVec;

  logic       start4, vecValid4;
  logic [3:0] vec4;
  logic [6:0] obs4;
  logic       busy4, done4, pass4, ffValid4;
  logic [4:0] checkCount4, errCount4;
  logic [3:0] ffVec4;

  response_checker #(.NUM_VECTORS(16), .ERR_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .vec_valid(vecValid),
    .vec(vec), .obs(obs), .busy(busy), .done(done), .pass(pass),
    .check_count(checkCount), .err_count(errCount),
    .first_fail_vec(ffVec), .first_fail_valid(ffValid)
  );

  response_checker #(.NUM_VECTORS(4), .ERR_W(5)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .vec_valid(vecValid4),
    .vec(vec4), .obs(obs4), .busy(busy4), .done(done4), .pass(pass4),
    .check_count(checkCount4), .err_count(errCount4),
    .first_fail_vec(ffVec4), .first_fail_valid(ffValid4)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference responses written straight from the circuit equations
  function automatic logic [6:0] refResp(input logic [3:0] v);
    bit a, b, c, d, f, f1, f2, f3, y1, y23;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    f   = b || c || !d;
    f2  = !b || !a || c;
    f3  = (b != d) && (a == c);
    f1  = !(f2 || f3);
    y1  = a || b;
    y23 = a && b;
    return {y23, y23, y1, f3, f2, f1, f};
  endfunction

  resT expQ[$];
  resT lastExp;
  int         mChecks, mErrs;
  logic       mFfValid, mInRun;
  logic [3:0] mFfVec;

  logic donePrev = 1'b0;
  always @(negedge clock) begin
    if (done && !donePrev) begin
      if (expQ.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        resT e;
        e = expQ.pop_front();
        check("run_check_count", 32'(checkCount), 32'(e.checks));
        check("run_err_count", 32'(errCount), 32'(e.errs));
        check("run_pass", 32'(pass), 32'(e.errs == 0));
        check("run_ff_valid", 32'(ffValid), 32'(e.ffValid));
        check("run_ff_vec", 32'(ffVec), 32'(e.ffVec));
      end
    end
    donePrev = done;
  end

  task automatic startRun();
    start = 1'b1; vecValid = 1'b0;
    mChecks = 0; mErrs = 0; mFfValid = 1'b0; mFfVec = '0; mInRun = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic applyVec(input logic [3:0] v, input logic [6:0] o, input bit valid, input bit st);
    vec = v; obs = o; vecValid = valid; start = st;
    if (valid && mInRun) begin
      mChecks++;
      if ($isunknown(o) || o !== refResp(v)) begin
        mErrs++;
        if (!mFfValid) begin
          mFfValid = 1'b1;
          mFfVec = v;
        end
      end
      if (mChecks == 16) begin
        lastExp = '{checks: mChecks, errs: mErrs, ffValid: mFfValid, ffVec: mFfVec};
        expQ.push_back(lastExp);
        mInRun = 1'b0;
      end
    end
    @(negedge clock);
    vecValid = 1'b0; start = 1'b0;
  endtask

  function automatic logic [6:0] randObs(input logic [3:0] v, input int errOneIn);
    logic [6:0] o;
    o = refResp(v);
    if ($urandom_range(errOneIn - 1, 0) == 0) o = o ^ (7'd1 << $urandom_range(6, 0));
    return o;
  endfunction

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_pass"}, 32'(pass), 32'(0));
    check({tag, "_counts"}, 32'({checkCount, errCount}), 32'(0));
    check({tag, "_ff"}, 32'({ffValid, ffVec}), 32'(0));
  endtask

  initial begin
    logic [3:0] v;
    reset_n = 1'b0; start = 1'b0; vecValid = 1'b0; vec = '0; obs = '0;
    start4 = 1'b0; vecValid4 = 1'b0; vec4 = '0; obs4 = '0;
    mInRun = 1'b0; mChecks = 0; mErrs = 0; mFfValid = 1'b0; mFfVec = '0;
    #1;
    checkAllZero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // All 16 vectors, descending, all correct
    startRun();
    check("busy_in_run", 32'(busy), 32'(1));
    for (int i = 15; i >= 0; i--) begin
      v = 4'(i);
      applyVec(v, refResp(v), 1'b1, 1'b0);
    end

    // Forced F1 fault on 1100 as vector 4, corrupted 0000 as the last vector
    startRun();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        applyVec(4'b1100, 7'b1110001, 1'b1, 1'b0);
        check("first_err_count", 32'(errCount), 32'(1));
        check("first_ff_vec", 32'(ffVec), 32'hC);
        check("first_ff_valid", 32'(ffValid), 32'(1));
      end else if (i == 15) begin
        applyVec(4'b0000, 7'b0000100, 1'b1, 1'b0);
      end else begin
        v = 4'($urandom_range(15, 0));
        if (v == 4'b0000) v = 4'b0001;
        applyVec(v, refResp(v), 1'b1, 1'b0);
      end
    end

    // Results must hold in DONE while vec_valid keeps toggling
    for (int i = 0; i < 4; i++) begin
      v = 4'($urandom_range(15, 0));
      applyVec(v, randObs(v, 2), 1'b1, 1'b0);
    end
    check("hold_done", 32'(done), 32'(1));
    check("hold_counts", 32'({checkCount, errCount}), 32'({5'(lastExp.checks), 5'(lastExp.errs)}));
    check("hold_ff", 32'({ffValid, ffVec}), 32'({lastExp.ffValid, lastExp.ffVec}));

    // Reset mid-run after 7 vectors
    startRun();
    for (int i = 0; i < 7; i++) begin
      v = 4'($urandom_range(15, 0));
      applyVec(v, randObs(v, 3), 1'b1, 1'b0);
    end
    #2 reset_n = 1'b0;
    mInRun = 1'b0;
    #1;
    checkAllZero("midrun_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("idle_after_reset", 32'({busy, done}), 32'(0));
    startRun();
    for (int i = 0; i < 16; i++) begin
      v = 4'($urandom_range(15, 0));
      applyVec(v, randObs(v, 4), 1'b1, 1'b0);
    end

    // Gaps and start pulses during a run
    startRun();
    while (mInRun) begin
      v = 4'($urandom_range(15, 0));
      applyVec(v, randObs(v, 3), ($urandom_range(2, 0) != 0), ($urandom_range(3, 0) == 0));
      check("gap_count", 32'(checkCount), 32'(mChecks));
    end

    // Further random runs
    for (int r = 0; r < 3; r++) begin
      startRun();
      for (int guard = 0; mInRun && guard < 200; guard++) begin
        v = 4'($urandom_range(15, 0));
        applyVec(v, randObs(v, 5), ($urandom_range(3, 0) != 0), ($urandom_range(5, 0) == 0));
      end
    end

    // Four-vector instance: an X in y3 on 1111 must count as a mismatch
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    vec4 = 4'hF; obs4 = 7'bx110101; vecValid4 = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check("n4_not_done", 32'(done4), 32'(0));
      vecValid4 = 1'b0;
      @(negedge clock);
      v = 4'($urandom_range(15, 0));
      vec4 = v; obs4 = refResp(v); vecValid4 = 1'b1;
      @(negedge clock);
    end
    vecValid4 = 1'b0;
    check("n4_done", 32'(done4), 32'(1));
    check("n4_busy", 32'(busy4), 32'(0));
    check("n4_check_count", 32'(checkCount4), 32'(4));
    check("n4_err_count", 32'(errCount4), 32'(1));
    check("n4_ff", 32'({ffValid4, ffVec4}), 32'h1F);
    check("n4_pass", 32'(pass4), 32'(0));

    repeat (3) @(negedge clock);
    check("pending_results", 32'(expQ.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
